// File: rtl/ii_pkg.sv
// Shared definitions for the integral-image builder: FSM state encoding,
// default geometry/width constants and the clamping adder used when
// INTEGRAL_SAT_EN is defined.
package ii_pkg;

  localparam int unsigned PIX_W_DEF     = 8;
  localparam int unsigned SUM_W_DEF     = 32;
  localparam int unsigned MAX_WIDTH_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

`ifdef INTEGRAL_SAT_EN
  // Add two values that each fit in w bits and clamp the result to 2^w-1.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] s;
    logic [63:0] m;
    s = a + b;
    m = (64'(1) << w) - 64'(1);
    return (s > m) ? m : s;
  endfunction
`endif

endpackage

// File: rtl/ii_line_buf.sv
// Previous-row storage for the integral-image builder.
// Ports: clk; wr_en/wr_addr/wr_data write port (synchronous);
// rd_addr/rd_data_c read port. The read is combinational from the array,
// so a read and a write to the same index in one cycle return the old
// (row-above) contents: read-before-write. The array has no reset.
module ii_line_buf #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read port: sees the value before this cycle's write lands
  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/integral_image_gen.sv
// Streaming summed-area (integral image) builder for one raster-order tile.
// Ports: clk, reset (sync, active-high); start/width/height frame setup;
// pix_valid/pix_ready/pix_data input stream; ii_valid/ii_ready/ii_data/
// ii_addr output stream with linear address y*width+x; frame_done pulse
// after the last output handshake; cfg_err sticky illegal-geometry flag.
// Build option: define INTEGRAL_SAT_EN to clamp the row sum and every ii
// value at 2^SUM_W-1 instead of wrapping modulo 2^SUM_W.
module integral_image_gen
  import ii_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int unsigned PIX_W     = PIX_W_DEF,
  parameter int unsigned SUM_W     = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      width,
  input  logic [15:0]      height,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  output logic             ii_valid,
  input  logic             ii_ready,
  output logic [SUM_W-1:0] ii_data,
  output logic [31:0]      ii_addr,
  output logic             frame_done,
  output logic             cfg_err
);

  localparam int unsigned XW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  state_e           state_q, state_d;
  logic [15:0]      x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [31:0]      addr_q, addr_d, ii_addr_q, ii_addr_d;
  logic [SUM_W-1:0] rs_q, rs_d, ii_data_q, ii_data_d;
  logic             ii_valid_q, ii_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             accept_c, geom_ok_c, last_px_c, row_end_c;
  logic [SUM_W-1:0] lb_rd_c, above_c, rs_nxt_c, ii_nxt_c;

  // Input side stalls whenever the single output register is full and blocked
  assign pix_ready = (state_q == RUN) && (!ii_valid_q || ii_ready);
  assign accept_c  = pix_valid && pix_ready;
  assign geom_ok_c = (width != 16'd0) && (32'(width) <= MAX_WIDTH) && (height != 16'd0);
  assign row_end_c = (x_q == w_q - 16'd1);
  assign last_px_c = row_end_c && (y_q == h_q - 16'd1);

  ii_line_buf #(
    .DEPTH (MAX_WIDTH),
    .DATA_W(SUM_W),
    .AW    (XW)
  ) u_line_buf (
    .clk      (clk),
    .wr_en    (accept_c),
    .wr_addr  (XW'(x_q)),
    .wr_data  (ii_nxt_c),
    .rd_addr  (XW'(x_q)),
    .rd_data_c(lb_rd_c)
  );

  // Datapath: row sum plus the row above; row 0 ignores stale buffer contents
  always_comb begin
    above_c = (y_q == 16'd0) ? '0 : lb_rd_c;
`ifdef INTEGRAL_SAT_EN
    rs_nxt_c = (x_q == 16'd0) ? SUM_W'(pix_data)
                              : SUM_W'(sat_add(64'(rs_q), 64'(pix_data), SUM_W));
    ii_nxt_c = SUM_W'(sat_add(64'(rs_nxt_c), 64'(above_c), SUM_W));
`else
    rs_nxt_c = (x_q == 16'd0) ? SUM_W'(pix_data) : rs_q + SUM_W'(pix_data);
    ii_nxt_c = rs_nxt_c + above_c;
`endif
  end

  // Next-state and register updates
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    addr_d       = addr_q;
    rs_d         = rs_q;
    ii_data_d    = ii_data_q;
    ii_addr_d    = ii_addr_q;
    ii_valid_d   = ii_valid_q;
    frame_done_d = 1'b0;
    cfg_err_d    = cfg_err_q;

    if (accept_c) begin
      ii_valid_d = 1'b1;
      ii_data_d  = ii_nxt_c;
      ii_addr_d  = addr_q;
      rs_d       = rs_nxt_c;
      addr_d     = addr_q + 32'd1;
      if (row_end_c) begin
        x_d = 16'd0;
        y_d = y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end else if (ii_ready) begin
      ii_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (geom_ok_c) begin
            state_d   = RUN;
            w_d       = width;
            h_d       = height;
            x_d       = 16'd0;
            y_d       = 16'd0;
            addr_d    = 32'd0;
            rs_d      = '0;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept_c && last_px_c) state_d = DRAIN;
      end
      DRAIN: begin
        if (ii_valid_q && ii_ready) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      w_q          <= 16'd0;
      h_q          <= 16'd0;
      addr_q       <= 32'd0;
      rs_q         <= '0;
      ii_data_q    <= '0;
      ii_addr_q    <= 32'd0;
      ii_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      addr_q       <= addr_d;
      rs_q         <= rs_d;
      ii_data_q    <= ii_data_d;
      ii_addr_q    <= ii_addr_d;
      ii_valid_q   <= ii_valid_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign ii_valid   = ii_valid_q;
  assign ii_data    = ii_data_q;
  assign ii_addr    = ii_addr_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_integral_image_gen.sv
// Bench for integral_image_gen: two instances (SUM_W 32 and SUM_W 10) run in
// lockstep on shared inputs; outputs are compared against rectangle sums of
// the frame's pixels, wrapped or clamped to the instance's width.
module tb_integral_image_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] width, height;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        ii_ready;

  logic        pix_ready_a, ii_valid_a, frame_done_a, cfg_err_a;
  logic [31:0] ii_data_a, ii_addr_a;
  logic        pix_ready_b, ii_valid_b, frame_done_b, cfg_err_b;
  logic [9:0]  ii_data_b;
  logic [31:0] ii_addr_b;

  integral_image_gen u_dut_a (
    .clk(clk), .reset(reset), .start(start), .width(width), .height(height),
    .pix_valid(pix_valid), .pix_ready(pix_ready_a), .pix_data(pix_data),
    .ii_valid(ii_valid_a), .ii_ready(ii_ready), .ii_data(ii_data_a),
    .ii_addr(ii_addr_a), .frame_done(frame_done_a), .cfg_err(cfg_err_a)
  );

  integral_image_gen #(.SUM_W(10)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .width(width), .height(height),
    .pix_valid(pix_valid), .pix_ready(pix_ready_b), .pix_data(pix_data),
    .ii_valid(ii_valid_b), .ii_ready(ii_ready), .ii_data(ii_data_b),
    .ii_addr(ii_addr_b), .frame_done(frame_done_b), .cfg_err(cfg_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     w;
    int     h;
    int     mode;     // 0 constant fill, 1 ramp 1..n, 2 random
    int     fill;
    int     rdy;      // 0 ready high, 1 toggling, 2 random ready/valid
    bit     noise;    // hold start high with bad geometry during the frame
    bit     has_exp;
    longint exp_last;
  } vec_t;

  vec_t        vecs [8];
  int unsigned px [$];
  int          fw;
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  longint      last_b;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Summed-area reference: direct rectangle sum, then wrap or clamp to sw bits
  function automatic longint ref_ii(input int idx, input int sw);
    longint s, m;
    int x, y;
    x = idx % fw;
    y = idx / fw;
    s = 0;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++)
        s += longint'(px[j*fw + i]);
    m = (longint'(1) << sw) - 1;
`ifdef INTEGRAL_SAT_EN
    return (s > m) ? m : s;
`else
    return s & m;
`endif
  endfunction

  task automatic run_frame(input vec_t v);
    int     n, in_cnt, out_cnt, done_cnt, last_hs, budget;
    bit     hold_v, exp_v;
    longint hold_da;
    n = v.w * v.h;
    fw = v.w;
    px.delete();
    for (int k = 0; k < n; k++)
      px.push_back(v.mode == 0 ? v.fill : v.mode == 1 ? k + 1 : $urandom_range(0, 255));
    in_cnt = 0; out_cnt = 0; done_cnt = 0; last_hs = -10;
    hold_v = 0; exp_v = 0; hold_da = 0;
    budget = 8 * n + 50;

    @(negedge clk);
    start = 1'b1; width = 16'(v.w); height = 16'(v.h);
    pix_valid = 1'b0; ii_ready = 1'b1;

    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start     = v.noise && (out_cnt < n);
      width     = 16'd0;
      height    = 16'd0;
      pix_valid = (in_cnt < n) && (v.rdy != 2 || $urandom_range(0, 1) == 1);
      pix_data  = (in_cnt < n) ? 8'(px[in_cnt]) : 8'($urandom);
      ii_ready  = (v.rdy == 0) ? 1'b1 : (v.rdy == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (cyc == 0) chk("cfg_err_after_start", cfg_err_a, 0);
      if (exp_v) chk("latency_valid", ii_valid_a, 1);
      exp_v = 0;
      if (hold_v) chk("held_data_addr", {ii_data_a, ii_addr_a}, hold_da);
      if (frame_done_a) begin
        done_cnt++;
        chk("done_timing", cyc, last_hs + 1);
        chk("b_done", frame_done_b, 1);
      end
      hold_v = ii_valid_a && !ii_ready;
      if (hold_v) begin
        hold_da = {ii_data_a, ii_addr_a};
        chk("stall_pix_ready", {pix_ready_a, pix_ready_b}, 0);
      end
      if (ii_valid_a && ii_ready && out_cnt < n) begin
        chk("ii_data", ii_data_a, ref_ii(out_cnt, 32));
        chk("ii_addr", ii_addr_a, out_cnt);
        chk("ii_data_w10", ii_data_b, ref_ii(out_cnt, 10));
        chk("b_valid_addr", {ii_valid_b, ii_addr_b}, {1'b1, 32'(out_cnt)});
        if (out_cnt == n - 1) begin
          last_b = ii_data_b;
          if (v.has_exp) chk("last_word", ii_data_a, v.exp_last);
        end
        out_cnt++;
        if (out_cnt == n) last_hs = cyc;
      end
      if (pix_valid && pix_ready_a) begin
        in_cnt++;
        exp_v = 1;
      end
      if (done_cnt > 0 && cyc >= last_hs + 3) break;
    end
    chk("done_count", done_cnt, 1);
    chk("word_count", out_cnt, n);
    chk("cfg_err_end", {cfg_err_a, cfg_err_b}, 0);
    start = 1'b0; pix_valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rv;
    vecs[0] = '{3, 3, 0, 1,   0, 0, 1, 9};
    vecs[1] = '{2, 2, 0, 255, 0, 0, 1, 1020};
    vecs[2] = '{2, 2, 0, 0,   0, 0, 1, 0};
    vecs[3] = '{4, 2, 1, 0,   1, 0, 1, 36};
    vecs[4] = '{3, 2, 0, 255, 0, 0, 1, 1530};
    vecs[5] = '{1, 4, 1, 0,   2, 1, 1, 10};
    vecs[6] = '{5, 1, 0, 1,   1, 0, 1, 5};
    vecs[7] = '{1024, 2, 0, 1, 0, 0, 1, 2048};

    reset = 1'b1; start = 1'b0; width = 16'd0; height = 16'd0;
    pix_valid = 1'b0; pix_data = 8'd0; ii_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pix_ready",  pix_ready_a,  0);
    chk("rst_ii_valid",   ii_valid_a,   0);
    chk("rst_ii_data",    ii_data_a,    0);
    chk("rst_ii_addr",    ii_addr_a,    0);
    chk("rst_frame_done", frame_done_a, 0);
    chk("rst_cfg_err",    cfg_err_a,    0);
    reset = 1'b0;

    // Illegal geometries: width 0, width MAX_WIDTH+1, height 0
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1;
      width  = (k == 0) ? 16'd0 : (k == 1) ? 16'd1025 : 16'd3;
      height = (k == 2) ? 16'd0 : 16'd3;
      @(negedge clk);
      start = 1'b0; pix_valid = 1'b1;
      #1;
      chk("cfg_err_set", {cfg_err_a, cfg_err_b}, 2'b11);
      @(negedge clk);
      #1;
      chk("cfg_pix_ready", {pix_ready_a, pix_ready_b}, 0);
      pix_valid = 1'b0;
    end

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i]);
      if (i == 4) begin
`ifdef INTEGRAL_SAT_EN
        chk("w10_last_sat", last_b, 1023);
`else
        chk("w10_last_wrap", last_b, 506);
`endif
      end
    end

    for (int r = 0; r < 6; r++) begin
      rv = '{int'($urandom_range(1, 8)), int'($urandom_range(1, 6)), 2, 0, 2, 1, 0, 0};
      run_frame(rv);
    end

    // Reset mid-frame after 5 pixels of a 4x4 all-ones frame
    @(negedge clk);
    start = 1'b1; width = 16'd4; height = 16'd4;
    @(negedge clk);
    start = 1'b0; pix_valid = 1'b1; pix_data = 8'd1; ii_ready = 1'b1;
    repeat (5) @(negedge clk);
    pix_valid = 1'b0;
    #1;
    chk("pre_rst_ii_data", ii_data_a, 2);
    chk("pre_rst_ii_addr", ii_addr_a, 4);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_pix_ready",  pix_ready_a,  0);
    chk("mid_rst_ii_valid",   ii_valid_a,   0);
    chk("mid_rst_ii_data",    ii_data_a,    0);
    chk("mid_rst_ii_addr",    ii_addr_a,    0);
    chk("mid_rst_frame_done", frame_done_a, 0);
    chk("mid_rst_cfg_err",    cfg_err_a,    0);
    reset = 1'b0;
    rv = '{4, 4, 0, 1, 0, 0, 1, 16};
    run_frame(rv);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/integral_image_gen.md
# integral_image_gen

Streaming integral-image builder that sits directly upstream of the face-detection cores. It accepts a raster-order 8-bit grayscale pixel stream for one core tile and emits, in the same order, the summed-area value ii(x,y) = Σ pix(i,j) for i≤x, j≤y. Each output word carries its linear tile address, so the detection core's four-corner box-sum lookups can read it directly. One output word is produced per accepted pixel.

## Interface
- MAX_WIDTH, 1024: largest supported tile row length; sets the line-buffer depth.
- PIX_W, 8: pixel width.
- SUM_W, 32: integral value width.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that latches `width`/`height` and begins a frame; ignored unless the block is in IDLE.
- width  in  16  tile row length in pixels.
- height  in  16  tile row count.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  input pixel accepted when both valid and ready are high.
- pix_data  in  PIX_W  unsigned pixel.
- ii_valid  out  1  output word valid.
- ii_ready  in  1  downstream can accept the output word.
- ii_data  out  SUM_W  integral value.
- ii_addr  out  32  linear address y*width + x.
- frame_done  out  1  single-cycle pulse after the last word is accepted downstream.
- cfg_err  out  1  sticky flag, set by an illegal geometry; cleared by the next legal `start`.

## Operation
- FSM states:
  - IDLE:
    - `start` with 1 ≤ width ≤ MAX_WIDTH and height ≥ 1 → RUN.
    - `start` with any other geometry → sets cfg_err and stays in IDLE.
  - RUN: accepts pixels; after the last pixel (x = width-1, y = height-1) is accepted → DRAIN.
  - DRAIN: once the final output word is accepted downstream → pulse frame_done, go to IDLE.
- Counters x, y run in raster order: x wraps to 0 at width-1 and y increments; both clear on `start`.
- Row accumulator: rs = pix when x = 0, otherwise rs + pix.
- Line buffer holds the previous row's ii values, MAX_WIDTH × SUM_W, with one read and one write per accepted pixel at index x.
- ii = rs + (y = 0 ? 0 : linebuf[x]).
  - The new ii is written back to linebuf[x] in the same cycle the pixel is accepted.
  - The read of linebuf[x] returns the row above, because index x was last written one row earlier.
- Arithmetic is unsigned. Without saturation, results wrap modulo 2^SUM_W.
- `start` while in RUN or DRAIN is ignored and does not touch cfg_err.
- `reset` mid-frame:
  - FSM → IDLE; counters, accumulator, ii_valid and frame_done are cleared.
  - Line-buffer contents are don't-care, since y = 0 bypasses the buffer.
- Reset values: pix_ready 0, ii_valid 0, ii_data 0, ii_addr 0, frame_done 0, cfg_err 0.

## Timing
- Latency: a pixel accepted in cycle N yields ii_valid high with its data in cycle N+1.
- One output register stage: pix_ready = (state == RUN) && (!ii_valid || ii_ready).
- Throughput is one pixel per cycle with no bubbles, including at row wrap.
- While ii_valid && !ii_ready, ii_data and ii_addr are held stable and no pixel is accepted.
- frame_done asserts in the cycle after the last output handshake; the next `start` is accepted one cycle later, in IDLE.
- The line-buffer read and write use the same index in the same cycle; read-before-write semantics are required.

## Configuration
- INTEGRAL_SAT_EN defined: every ii result, and the row accumulator, clamps to 2^SUM_W-1 instead of wrapping.
  - A saturated value, once reached, stays saturated for the rest of its row/column dependents.
- Macro undefined: modulo-2^SUM_W wrap and no clamp logic.

## Structure
- Package `ii_pkg` holds:
  - the FSM state enum (IDLE, RUN, DRAIN);
  - the default constants for PIX_W, SUM_W and MAX_WIDTH;
  - a saturating-add function, used only when INTEGRAL_SAT_EN is defined.
- Sub-module `ii_line_buf`: a single-clock, one-read/one-write RAM of MAX_WIDTH × SUM_W with read-before-write semantics, synchronous to clk, and no reset on the array.

## Test plan
- 3×3 tile, all pixels 1, ii_ready held high → ii_data 1,2,3,2,4,6,3,6,9; ii_addr 0..8; frame_done pulses once, one cycle after the 9th word.
- 2×2 tile of 255 → 255, 510, 510, 1020; then a second `start` with a 2×2 tile of 0 → all 0, proving no state leaks between frames.
- 4×2 tile with a ramp 1..8 and ii_ready toggling every other cycle → 1,3,6,10,6,14,24,36, with data held stable whenever ii_ready is low.
- SUM_W = 10, 3×2 tile of 255 → last word 1023 with INTEGRAL_SAT_EN defined, 506 without it.
- `start` with width = 0, then width = MAX_WIDTH+1 → cfg_err set, pix_ready stays 0; a following legal `start` clears cfg_err.
- `reset` asserted after 5 pixels of a 4×4 frame → all outputs return to reset values next cycle; a new 4×4 all-ones frame then ends with ii = 16.
